csr_timer_multi: RTL and testbench



---
 rtl/csr_pkg.sv | 32 +++
 rtl/csr_timer_channel.sv | 74 +++++++
 rtl/csr_timer_multi.sv | 135 +++++++++++++
 tb/tb_csr_timer_multi.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR side-bus op encodings, addresses and timer register map
package csr_pkg;

  localparam logic [2:0] CSR_OP_NONE  = 3'd0;
  localparam logic [2:0] CSR_OP_WRITE = 3'd1;
  localparam logic [2:0] CSR_OP_SET   = 3'd2;
  localparam logic [2:0] CSR_OP_CLEAR = 3'd3;

  localparam logic [11:0] CSR_UART  = 12'hbc0;
  localparam logic [11:0] CSR_SWI   = 12'hbc1;
  localparam logic [11:0] CSR_TIMER = 12'hbc2;
  localparam logic [11:0] CSR_SIM   = 12'h3ff;

  localparam logic [11:0] OFF_COUNT  = 12'd0;
  localparam logic [11:0] OFF_PEND   = 12'd1;
  localparam logic [11:0] OFF_CTRL   = 12'd2;
  localparam logic [11:0] OFF_CMP0   = 12'd3;
  localparam logic [11:0] OFF_STRIDE = 12'd2;

  // New register value for a write / bit-set / bit-clear; anything else keeps the old value.
  function automatic logic [31:0] csr_apply(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [2:0]  op);
    case (op)
      CSR_OP_WRITE: csr_apply = wdata;
      CSR_OP_SET:   csr_apply = old_val | wdata;
      CSR_OP_CLEAR: csr_apply = old_val & ~wdata;
      default:      csr_apply = old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_timer_channel.sv
// rtl/csr_timer_channel.sv - one compare channel: CMP, PERIOD, ARMED, PEND and match
module csr_timer_channel
  import csr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick,
  input  logic [WIDTH-1:0] count,
  input  logic             periodic,
  input  logic [2:0]       op,
  input  logic [31:0]      wdata,
  input  logic             cmp_wr,
  input  logic             period_wr,
  input  logic             pend_wr,
  input  logic             pend_new,
  input  logic             armed_wr,
  input  logic             armed_new,
  output logic [WIDTH-1:0] cmp,
  output logic [WIDTH-1:0] period,
  output logic             pend,
  output logic             armed
);

  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             pend_q, pend_d;
  logic             armed_q, armed_d;
  logic             match;

  // Equality on the pre-increment count, so wrap-around needs no special case.
  assign match = tick & armed_q & (count == cmp_q);

  // Hardware match first, then software writes override; a pending event is never lost.
  always_comb begin
    cmp_d    = cmp_q;
    period_d = period_q;
    armed_d  = armed_q;
    pend_d   = pend_q | match;
    if (match) begin
      if (periodic) cmp_d = cmp_q + period_q;
      else          armed_d = 1'b0;
    end
    if (armed_wr)  armed_d  = armed_new;
    if (cmp_wr) begin
      cmp_d   = WIDTH'(csr_apply(32'(cmp_q), wdata, op));
      armed_d = 1'b1;
    end
    if (period_wr) period_d = WIDTH'(csr_apply(32'(period_q), wdata, op));
    if (pend_wr)   pend_d   = pend_new | match;
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_q    <= '1;
      period_q <= '0;
      pend_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      cmp_q    <= cmp_d;
      period_q <= period_d;
      pend_q   <= pend_d;
      armed_q  <= armed_d;
    end
  end

  assign cmp    = cmp_q;
  assign period = period_q;
  assign pend   = pend_q;
  assign armed  = armed_q;

endmodule

// File: rtl/csr_timer_multi.sv
// rtl/csr_timer_multi.sv - prescaled free-running counter shared by several compare channels
module csr_timer_multi
  import csr_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = CSR_TIMER,
  parameter int          WIDTH     = 32,
  parameter int          CHANNELS  = 2,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        irq
);

  localparam int          PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [11:0] NUM_REGS = 12'(OFF_CMP0 + OFF_STRIDE * CHANNELS);

  logic [11:0]         off;
  logic                hit;
  logic                mod_en;
  logic                tick;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [CHANNELS-1:0] ien_q, ien_d;
  logic [CHANNELS-1:0] periodic_q, periodic_d;
  logic [CHANNELS-1:0] pend, armed, pend_new, armed_new;
  logic [WIDTH-1:0]    cmp [CHANNELS];
  logic [WIDTH-1:0]    period [CHANNELS];
  logic [31:0]         ctrl_rd, rd_val;
  logic [31:0]         rdata_q, rdata_d;
  logic                valid_q, valid_d;

  // Address decode; addresses below BASE_ADDR wrap to large offsets and miss.
  always_comb begin
    off    = addr - BASE_ADDR;
    hit    = off < NUM_REGS;
    mod_en = hit & ((modify == CSR_OP_WRITE) | (modify == CSR_OP_SET) | (modify == CSR_OP_CLEAR));
  end

  assign tick    = (pre_q == PRE_W'(PRESCALE - 1));
  assign ctrl_rd = {8'd0, 8'(armed), 8'(periodic_q), 8'(ien_q)};

  // Software view of PEND and ARMED after the pending op, fed to every channel.
  always_comb begin
    pend_new  = CHANNELS'(csr_apply(32'(pend), wdata, modify));
    armed_new = CHANNELS'(csr_apply(ctrl_rd, wdata, modify) >> 16);
  end

  // Prescaler and counter; a software COUNT access wins and restarts the prescaler.
  always_comb begin
    pre_d   = tick ? '0 : pre_q + PRE_W'(1);
    count_d = tick ? count_q + WIDTH'(1) : count_q;
    if (mod_en && off == OFF_COUNT) begin
      count_d = WIDTH'(csr_apply(32'(count_q), wdata, modify));
      pre_d   = '0;
    end
  end

  // CTRL enable and mode bits.
  always_comb begin
    ien_d      = ien_q;
    periodic_d = periodic_q;
    if (mod_en && off == OFF_CTRL) begin
      ien_d      = CHANNELS'(csr_apply(ctrl_rd, wdata, modify));
      periodic_d = CHANNELS'(csr_apply(ctrl_rd, wdata, modify) >> 8);
    end
  end

  // Read mux over the decoded registers; returns the pre-modify value.
  always_comb begin
    rd_val = '0;
    if (off == OFF_COUNT) rd_val = 32'(count_q);
    if (off == OFF_PEND)  rd_val = 32'(pend);
    if (off == OFF_CTRL)  rd_val = ctrl_rd;
    for (int c = 0; c < CHANNELS; c++) begin
      if (off == 12'(OFF_CMP0 + OFF_STRIDE * c))         rd_val = 32'(cmp[c]);
      if (off == 12'(OFF_CMP0 + OFF_STRIDE * c + 12'd1)) rd_val = 32'(period[c]);
    end
    valid_d = read & hit;
    rdata_d = (read & hit) ? rd_val : '0;
  end

  // Top-level state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q    <= '0;
      pre_q      <= '0;
      ien_q      <= '0;
      periodic_q <= '0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      pre_q      <= pre_d;
      ien_q      <= ien_d;
      periodic_q <= periodic_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [11:0] CMP_OFF = 12'(OFF_CMP0 + OFF_STRIDE * c);
    csr_timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .tick      (tick),
      .count     (count_q),
      .periodic  (periodic_q[c]),
      .op        (modify),
      .wdata     (wdata),
      .cmp_wr    (mod_en && off == CMP_OFF),
      .period_wr (mod_en && off == CMP_OFF + 12'd1),
      .pend_wr   (mod_en && off == OFF_PEND),
      .pend_new  (pend_new[c]),
      .armed_wr  (mod_en && off == OFF_CTRL),
      .armed_new (armed_new[c]),
      .cmp       (cmp[c]),
      .period    (period[c]),
      .pend      (pend[c]),
      .armed     (armed[c])
    );
  end

  assign rdata = rdata_q;
  assign valid = valid_q;
  assign irq   = |(pend & ien_q);

endmodule

// File: tb/tb_csr_timer_multi.sv
// tb/tb_csr_timer_multi.sv - directed self-checking bench for csr_timer_multi
module tb_csr_timer_multi;
  import csr_pkg::*;

  localparam logic [11:0] BA = 12'hbc2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        read;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata_a, rdata_b;
  logic        valid_a, valid_b;
  logic        irq_a, irq_b;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  csr_timer_multi #(.BASE_ADDR(BA), .WIDTH(8), .CHANNELS(2), .PRESCALE(1)) u_a (
    .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata), .addr(addr),
    .rdata(rdata_a), .valid(valid_a), .irq(irq_a)
  );

  csr_timer_multi #(.BASE_ADDR(BA), .WIDTH(32), .CHANNELS(2), .PRESCALE(4)) u_b (
    .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata), .addr(addr),
    .rdata(rdata_b), .valid(valid_b), .irq(irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input logic rd, input logic [2:0] op, input logic [11:0] o, input logic [31:0] wd);
    read   = rd;
    modify = op;
    addr   = BA + o;
    wdata  = wd;
    @(posedge clk);
    #1;
    read   = 1'b0;
    modify = CSR_OP_NONE;
    addr   = 12'd0;
    wdata  = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; read = 1'b0; modify = CSR_OP_NONE; wdata = 32'd0; addr = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_irq", 32'(irq_a), 32'd0);
    chk("rst_count", 32'(u_a.count_q), 32'd0);
    rstn = 1'b1;

    // reset values and decode boundaries
    cyc(1'b1, CSR_OP_NONE, 12'd0, 32'd0);
    chk("rd_count_valid", 32'(valid_a), 32'd1);
    chk("rd_count", rdata_a, 32'd0);
    cyc(1'b1, CSR_OP_NONE, 12'd3, 32'd0);
    chk("rd_cmp0_w8", rdata_a, 32'h0000_00ff);
    chk("rd_cmp0_w32", rdata_b, 32'hffff_ffff);
    cyc(1'b1, CSR_OP_NONE, 12'd20, 32'd0);
    chk("rd_off20_valid", 32'(valid_a), 32'd0);
    chk("rd_off20_rdata", rdata_a, 32'd0);
    cyc(1'b1, CSR_OP_NONE, 12'd7, 32'd0);
    chk("rd_off7_valid", 32'(valid_a), 32'd0);
    cyc(1'b1, CSR_OP_NONE, 12'd6, 32'd0);
    chk("rd_period1_valid", 32'(valid_a), 32'd1);
    chk("rd_period1", rdata_a, 32'd0);
    cyc(1'b1, CSR_OP_NONE, 12'hfff, 32'd0);
    chk("rd_below_base", 32'(valid_a), 32'd0);

    // one-shot: COUNT=10, CMP0=20 -> match 11 edges after the COUNT write
    cyc(1'b0, CSR_OP_SET, 12'd2, 32'h1);
    cyc(1'b0, CSR_OP_WRITE, 12'd0, 32'd10);
    cyc(1'b0, CSR_OP_WRITE, 12'd3, 32'd20);
    idle(9);
    chk("os_irq_before", 32'(irq_a), 32'd0);
    idle(1);
    chk("os_irq", 32'(irq_a), 32'd1);
    cyc(1'b1, CSR_OP_NONE, 12'd2, 32'd0);
    chk("os_ctrl_disarmed", rdata_a, 32'h0000_0001);
    cyc(1'b0, CSR_OP_CLEAR, 12'd1, 32'h1);
    chk("os_irq_cleared", 32'(irq_a), 32'd0);
    idle(300);
    chk("os_irq_after_wrap", 32'(irq_a), 32'd0);
    cyc(1'b1, CSR_OP_NONE, 12'd1, 32'd0);
    chk("os_pend_after_wrap", rdata_a, 32'd0);

    // periodic with wrap: COUNT=240, CMP0=250, PERIOD0=10 -> 250 then 4
    cyc(1'b0, CSR_OP_SET, 12'd2, 32'h100);
    cyc(1'b0, CSR_OP_WRITE, 12'd4, 32'd10);
    cyc(1'b0, CSR_OP_WRITE, 12'd0, 32'd240);
    cyc(1'b0, CSR_OP_WRITE, 12'd3, 32'd250);
    idle(9);
    chk("per_irq_before", 32'(irq_a), 32'd0);
    idle(1);
    chk("per_irq_250", 32'(irq_a), 32'd1);
    cyc(1'b1, CSR_OP_NONE, 12'd3, 32'd0);
    chk("per_cmp_4", rdata_a, 32'd4);
    cyc(1'b0, CSR_OP_CLEAR, 12'd1, 32'h1);
    chk("per_irq_clr", 32'(irq_a), 32'd0);
    idle(7);
    chk("per_irq_before_wrap", 32'(irq_a), 32'd0);
    idle(1);
    chk("per_irq_4", 32'(irq_a), 32'd1);
    cyc(1'b1, CSR_OP_NONE, 12'd3, 32'd0);
    chk("per_cmp_14", rdata_a, 32'd14);
    cyc(1'b0, CSR_OP_CLEAR, 12'd2, 32'h0001_0100);
    cyc(1'b0, CSR_OP_CLEAR, 12'd1, 32'h3);

    // hardware PEND set wins over a software clear on the same edge
    cyc(1'b0, CSR_OP_WRITE, 12'd0, 32'd40);
    cyc(1'b0, CSR_OP_WRITE, 12'd3, 32'd50);
    idle(9);
    cyc(1'b0, CSR_OP_CLEAR, 12'd1, 32'h1);
    cyc(1'b1, CSR_OP_NONE, 12'd1, 32'd0);
    chk("col_pend_kept", rdata_a, 32'd1);
    chk("col_irq_kept", 32'(irq_a), 32'd1);
    cyc(1'b0, CSR_OP_CLEAR, 12'd1, 32'h1);
    cyc(1'b1, CSR_OP_NONE, 12'd1, 32'd0);
    chk("col_pend_clr", rdata_a, 32'd0);

    // software COUNT write beats the increment on a tick edge
    cyc(1'b0, CSR_OP_WRITE, 12'd0, 32'd100);
    cyc(1'b1, CSR_OP_NONE, 12'd0, 32'd0);
    chk("cnt_write_wins", rdata_a, 32'd100);
    cyc(1'b1, CSR_OP_NONE, 12'd0, 32'd0);
    chk("cnt_increments", rdata_a, 32'd101);

    // two channels at CMP=7 set both PEND bits on the same edge
    cyc(1'b0, CSR_OP_WRITE, 12'd0, 32'd0);
    cyc(1'b0, CSR_OP_WRITE, 12'd3, 32'd7);
    cyc(1'b0, CSR_OP_WRITE, 12'd5, 32'd7);
    idle(5);
    cyc(1'b1, CSR_OP_NONE, 12'd1, 32'd0);
    chk("two_pend_before", rdata_a, 32'd0);
    cyc(1'b1, CSR_OP_NONE, 12'd1, 32'd0);
    chk("two_pend_both", rdata_a, 32'd3);
    cyc(1'b1, CSR_OP_NONE, 12'd2, 32'd0);
    chk("two_ctrl_disarmed", rdata_a, 32'h0000_0001);
    cyc(1'b0, CSR_OP_CLEAR, 12'd1, 32'h3);

    // software CMP write on the match edge: new CMP wins, PEND still sets, re-armed
    cyc(1'b0, CSR_OP_WRITE, 12'd0, 32'd20);
    cyc(1'b0, CSR_OP_WRITE, 12'd3, 32'd30);
    idle(9);
    cyc(1'b0, CSR_OP_WRITE, 12'd3, 32'd99);
    cyc(1'b1, CSR_OP_NONE, 12'd3, 32'd0);
    chk("swcmp_cmp", rdata_a, 32'd99);
    cyc(1'b1, CSR_OP_NONE, 12'd1, 32'd0);
    chk("swcmp_pend", rdata_a, 32'd1);
    cyc(1'b1, CSR_OP_NONE, 12'd2, 32'd0);
    chk("swcmp_armed", rdata_a, 32'h0001_0001);

    // prescale 4 on the second instance: COUNT=0, CMP0=3 -> match 16 edges later
    cyc(1'b0, CSR_OP_CLEAR, 12'd2, 32'h0003_0100);
    cyc(1'b0, CSR_OP_CLEAR, 12'd1, 32'h3);
    cyc(1'b0, CSR_OP_WRITE, 12'd0, 32'd0);
    cyc(1'b0, CSR_OP_WRITE, 12'd3, 32'd3);
    idle(2);
    cyc(1'b1, CSR_OP_NONE, 12'd0, 32'd0);
    chk("pre_cnt_0", rdata_b, 32'd0);
    chk("pre_valid", 32'(valid_b), 32'd1);
    cyc(1'b1, CSR_OP_NONE, 12'd0, 32'd0);
    chk("pre_cnt_1", rdata_b, 32'd1);
    idle(2);
    cyc(1'b1, CSR_OP_NONE, 12'd0, 32'd0);
    chk("pre_cnt_1_hold", rdata_b, 32'd1);
    cyc(1'b1, CSR_OP_NONE, 12'd0, 32'd0);
    chk("pre_cnt_2", rdata_b, 32'd2);
    idle(6);
    chk("pre_irq_before", 32'(irq_b), 32'd0);
    idle(1);
    chk("pre_irq", 32'(irq_b), 32'd1);
    cyc(1'b0, CSR_OP_CLEAR, 12'd1, 32'h1);
    chk("pre_irq_clr", 32'(irq_b), 32'd0);
    idle(40);
    chk("pre_irq_once", 32'(irq_b), 32'd0);
    cyc(1'b1, CSR_OP_NONE, 12'd1, 32'd0);
    chk("pre_pend_once", rdata_b, 32'd0);

    // asynchronous reset mid-cycle while irq and valid are high
    cyc(1'b1, CSR_OP_SET, 12'd1, 32'h1);
    chk("ar_valid_hi", 32'(valid_a), 32'd1);
    chk("ar_irq_hi", 32'(irq_a), 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    chk("ar_irq", 32'(irq_a), 32'd0);
    chk("ar_irq_b", 32'(irq_b), 32'd0);
    chk("ar_valid", 32'(valid_a), 32'd0);
    chk("ar_count", 32'(u_a.count_q), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc(1'b1, CSR_OP_NONE, 12'd0, 32'd0);
    chk("ar_rd_count", rdata_a, 32'd0);
    cyc(1'b1, CSR_OP_NONE, 12'd3, 32'd0);
    chk("ar_rd_cmp0", rdata_a, 32'h0000_00ff);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
